color_mixer_signed_stream: RTL

- Parametrised successor to the fixed 4x9-bit signed colour mixer. Used in the texture environment and blend stages of the fragment pipeline.
- Computes per sub-pixel a selectable signed combination of two products, with programmable rounding bias and saturation.
- Adds valid/ready flow control with a stall-capable 2-stage pipeline and a sideband tag that travels with each beat.

---
 rtl/color_mixer_signed_stream_pkg.sv | 31 +++
 rtl/color_mixer_signed_stream_if.sv | 36 +++
 rtl/color_mixer_signed_stream_lane.sv | 77 +++++++
 rtl/color_mixer_signed_stream.sv | 77 +++++++
 4 files changed

// File: rtl/color_mixer_signed_stream_pkg.sv
// Shared definitions for the signed colour mixer stream.
//   - mix_mode_e : per-beat combination of the two lane products
//   - PROD_WIDTH : full-precision product width for a W-bit signed sub-pixel
//   - SUM_WIDTH  : width of the combined sum, with headroom for the bias
//   - DEFAULT_BIAS / BIAS_DEFAULT : legacy rounding bias (2^(W-1)-1)
package color_mixer_pkg;

  typedef enum logic [1:0] {
    MIX_ADD  = 2'd0,  // A*B + C*D
    MIX_SUB  = 2'd1,  // A*B - C*D
    MIX_MUL  = 2'd2,  // A*B
    MIX_RSUB = 2'd3   // C*D - A*B
  } mix_mode_e;

  // 2W keeps (-2^F)^2 exact.
  function automatic int PROD_WIDTH(input int w);
    return 2 * w;
  endfunction

  // Two extra bits cover the sum/difference of two products plus the bias.
  function automatic int SUM_WIDTH(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int DEFAULT_BIAS(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  localparam int BIAS_DEFAULT = DEFAULT_BIAS(9);

endpackage

// File: rtl/color_mixer_signed_stream_if.sv
// Stream bundle for the colour mixer: input beat (valid/ready, mode, tag,
// four packed signed colours) and output beat (valid/ready, colour, tag).
//   slave  : the mixer side (consumes s_*, produces m_*)
//   master : the producer/consumer around the mixer
interface color_mixer_signed_stream_if #(
  parameter int W          = 9,
  parameter int N          = 4,
  parameter int USER_WIDTH = 8
);

  logic                  s_valid;
  logic                  s_ready;
  logic [1:0]            s_mode;
  logic [USER_WIDTH-1:0] s_user;
  logic [N*W-1:0]        s_colorA;
  logic [N*W-1:0]        s_colorB;
  logic [N*W-1:0]        s_colorC;
  logic [N*W-1:0]        s_colorD;
  logic                  m_valid;
  logic                  m_ready;
  logic [N*W-1:0]        m_color;
  logic [USER_WIDTH-1:0] m_user;

  modport slave (
    input  s_valid, s_mode, s_user, s_colorA, s_colorB, s_colorC, s_colorD,
    input  m_ready,
    output s_ready, m_valid, m_color, m_user
  );

  modport master (
    output s_valid, s_mode, s_user, s_colorA, s_colorB, s_colorC, s_colorD,
    output m_ready,
    input  s_ready, m_valid, m_color, m_user
  );

endinterface

// File: rtl/color_mixer_signed_stream_lane.sv
// One sub-pixel of the mixer through both pipeline stages.
//   aclk, resetn : clock, async active-low reset
//   en1          : stage-1 load (products of the incoming beat)
//   en2          : stage-2 load (combine, bias, shift, clamp)
//   a, b, c, d   : signed sub-pixels of the incoming beat
//   mode         : mode of the beat held in stage 1
//   color        : saturated signed result (stage-2 register)
module color_mixer_lane
  import color_mixer_pkg::*;
#(
  parameter int W    = 9,
  parameter int BIAS = DEFAULT_BIAS(W)
) (
  input  logic                aclk,
  input  logic                resetn,
  input  logic                en1,
  input  logic                en2,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  input  mix_mode_e           mode,
  output logic signed [W-1:0] color
);

  localparam int PW = PROD_WIDTH(W);
  localparam int SW = SUM_WIDTH(W);
  localparam int F  = W - 1;

  localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
  localparam logic signed [SW-1:0] MAX_S  = SW'((1 << (W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_S  = -MAX_S - SW'(1);

  logic signed [PW-1:0] p_ab, p_cd;
  logic signed [SW-1:0] ab_x, cd_x, sum, biased, t;
  logic signed [W-1:0]  sat;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      p_ab <= '0;
      p_cd <= '0;
    end else if (en1) begin
      p_ab <= PW'(a) * PW'(b);
      p_cd <= PW'(c) * PW'(d);
    end
  end

  always_comb begin
    ab_x = SW'(p_ab);
    cd_x = SW'(p_cd);
    sum  = '0;
    case (mode)
      MIX_ADD:  sum = ab_x + cd_x;
      MIX_SUB:  sum = ab_x - cd_x;
      MIX_MUL:  sum = ab_x;
      MIX_RSUB: sum = cd_x - ab_x;
      default:  sum = '0;
    endcase
    biased = sum + BIAS_S;
    // Arithmetic shift rounds toward minus infinity; BIAS picks the rounding.
    t = biased >>> F;
    if (t > MAX_S)
      sat = {1'b0, {(W-1){1'b1}}};
    else if (t < MIN_S)
      sat = {1'b1, {(W-1){1'b0}}};
    else
      sat = t[W-1:0];
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn)
      color <= '0;
    else if (en2)
      color <= sat;
  end

endmodule

// File: rtl/color_mixer_signed_stream.sv
// Signed colour mixer with valid/ready flow control and a 2-stage pipeline.
//   aclk, resetn : clock, async active-low reset
//   bus (slave)  : s_valid/s_ready/s_mode/s_user/s_colorA..D in,
//                  m_valid/m_ready/m_color/m_user out
// Each of the N lanes computes a mode-selected combination of A*B and C*D,
// adds BIAS, shifts right by W-1 and saturates to W signed bits. The tag in
// s_user travels alongside the beat unchanged.
module color_mixer_signed_stream
  import color_mixer_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH     = 9,
  parameter int NUMBER_OF_SUB_PIXEL = 4,
  parameter int USER_WIDTH          = 8,
  parameter int BIAS                = DEFAULT_BIAS(SUB_PIXEL_WIDTH)
) (
  input  logic                         aclk,
  input  logic                         resetn,
  color_mixer_signed_stream_if.slave   bus
);

  localparam int W = SUB_PIXEL_WIDTH;
  localparam int N = NUMBER_OF_SUB_PIXEL;

  logic                  v1, m_valid_q;
  logic                  en1, en2;
  mix_mode_e             mode1;
  logic [USER_WIDTH-1:0] user1, m_user_q;
  logic [N*W-1:0]        m_color_q;

  // Stage 2 advances when empty or drained; stage 1 advances when empty or
  // when stage 2 advances, so a bubble in stage 1 is always refillable.
  assign en2         = !m_valid_q || bus.m_ready;
  assign en1         = !v1 || en2;
  assign bus.s_ready = en1;
  assign bus.m_valid = m_valid_q;
  assign bus.m_user  = m_user_q;
  assign bus.m_color = m_color_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      v1        <= 1'b0;
      mode1     <= MIX_ADD;
      user1     <= '0;
      m_valid_q <= 1'b0;
      m_user_q  <= '0;
    end else begin
      if (en1) begin
        v1    <= bus.s_valid;
        mode1 <= mix_mode_e'(bus.s_mode);
        user1 <= bus.s_user;
      end
      if (en2) begin
        m_valid_q <= v1;
        m_user_q  <= user1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    color_mixer_lane #(
      .W    (W),
      .BIAS (BIAS)
    ) u_lane (
      .aclk   (aclk),
      .resetn (resetn),
      .en1    (en1),
      .en2    (en2),
      .a      (bus.s_colorA[i*W +: W]),
      .b      (bus.s_colorB[i*W +: W]),
      .c      (bus.s_colorC[i*W +: W]),
      .d      (bus.s_colorD[i*W +: W]),
      .mode   (mode1),
      .color  (m_color_q[i*W +: W])
    );
  end

endmodule
